updi_rx: RTL

- UART receiver for the UPDI single-wire link. Deserialises 8E2 frames (start, 8 data LSB-first, even parity, 2 stop) from the synchronised pin.
- Writes good bytes into the RX FIFO that feeds updi_input_handler.
- Flags parity, framing and overflow errors. Detects BREAK (line held low at least one frame).
- Gated by rx_en so the host can ignore its own echo during transmit.

---
 rtl/updi_rx.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/updi_rx.sv
// UPDI UART receiver: 8E2 frames from a synchronised pin into the RX FIFO,
// with parity/framing/overflow error pulses and BREAK detection.
module updi_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       rx_en,
  output logic [7:0] fifo_data,
  input  logic       fifo_full,
  output logic       fifo_wr_en,
  output logic       parity_error,
  output logic       frame_error,
  output logic       overflow,
  output logic       break_det,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH} state_e;

  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  state_e           state_q, state_d;
  logic             rs1_q, rs_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic             stop1_q, stop1_d;
  logic             brk_q, brk_d;
  logic [7:0]       data_q, data_d;
  logic             wr_q, wr_d, perr_q, perr_d, ferr_q, ferr_d;
  logic             ovf_q, ovf_d, bdet_q, bdet_d;

  // Sample strobe: half a bit into the start bit, then one full bit later each time.
  logic mid, stop_bad, is_brk, par_bad, eval;
  assign mid      = (state_q == START) ? (cnt_q == HALF) : (cnt_q == LAST);
  assign stop_bad = ~stop1_q | ~rs_q;
  assign is_brk   = stop_bad & (shift_q == 8'h00) & ~par_q;
  assign par_bad  = ^{shift_q, par_q};
  assign eval     = rx_en & (state_q == STOP2) & mid;

  // Two-flop synchroniser (preset high = idle line) and all state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_q   <= 1'b1;
      rs_q    <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      stop1_q <= 1'b0;
      brk_q   <= 1'b0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
      bdet_q  <= 1'b0;
    end else begin
      rs1_q   <= rx;
      rs_q    <= rs1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      stop1_q <= stop1_d;
      brk_q   <= brk_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
      bdet_q  <= bdet_d;
    end
  end

  // Next-state: bit timing, shift-in, and frame sequencing; rx_en low wins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    stop1_d = stop1_q;
    brk_d   = brk_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rs_q) state_d = START;
      end
      START: if (mid) begin
        cnt_d   = '0;
        bit_d   = '0;
        state_d = rs_q ? IDLE : DATA;
      end
      DATA: if (mid) begin
        cnt_d   = '0;
        shift_d = {rs_q, shift_q[7:1]};
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (mid) begin
        cnt_d   = '0;
        par_d   = rs_q;
        state_d = STOP1;
      end
      STOP1: if (mid) begin
        cnt_d   = '0;
        stop1_d = rs_q;
        state_d = STOP2;
      end
      STOP2: if (mid) begin
        // Return to IDLE mid-stop-bit so a start edge at the next boundary is caught.
        cnt_d   = '0;
        brk_d   = is_brk;
        state_d = stop_bad ? WAIT_HIGH : IDLE;
      end
      WAIT_HIGH: begin
        cnt_d = '0;
        if (rs_q) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    if (!rx_en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // Output pulses: prioritised frame verdict at the second stop sample, break on release.
  always_comb begin
    wr_d   = 1'b0;
    perr_d = 1'b0;
    ferr_d = 1'b0;
    ovf_d  = 1'b0;
    data_d = data_q;
    bdet_d = rx_en & (state_q == WAIT_HIGH) & rs_q & brk_q;
    if (eval && !is_brk) begin
      if (stop_bad)       ferr_d = 1'b1;
      else if (par_bad)   perr_d = 1'b1;
      else if (fifo_full) ovf_d  = 1'b1;
      else begin
        wr_d   = 1'b1;
        data_d = shift_q;
      end
    end
  end

  assign fifo_data    = data_q;
  assign fifo_wr_en   = wr_q;
  assign parity_error = perr_q;
  assign frame_error  = ferr_q;
  assign overflow     = ovf_q;
  assign break_det    = bdet_q;
  assign busy         = (state_q != IDLE);

endmodule
